// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and hands each returned word to the IR with a one-cycle write strobe.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir_din,
    output logic              ir_write_en,
    input  logic              fetch_next,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOAD,
        EXEC
    } state_t;

    state_t state, state_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (run) state_next = REQ;
            REQ:  if (imem_ack) state_next = LOAD;
            LOAD: state_next = EXEC;
            EXEC: if (jump_en || fetch_next) state_next = run ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A jump and a fetch request in the same EXEC cycle share one fetch, from jump_addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            ir_din <= '0;
        end else begin
            if (state == REQ && imem_ack)
                ir_din <= imem_rdata;
            if (state == LOAD)
                pc <= pc + ADDR_W'(1);
            else if (state == EXEC && jump_en)
                pc <= jump_addr;
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign ir_write_en = (state == LOAD);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder with wait states,
// scoreboard of expected IR words and post-load PC values.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  pc_after;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, run, fetch_next, jump_en;
    logic        imem_req, imem_ack, ir_write_en, busy;
    logic [7:0]  imem_addr, jump_addr, pc;
    logic [15:0] imem_rdata, ir_din;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [15:0] mem [256];
    logic [7:0]  model_pc = 8'h00;
    logic        mem_enable = 1'b0;
    int          mem_wait = 0;
    logic        force_ack = 1'b0;
    logic [15:0] force_data = 16'h0000;

    logic        resp_ack = 1'b0;
    logic [15:0] resp_data = 16'h0000;
    logic        in_req = 1'b0;
    int          wait_cnt = 0;
    logic        ack_prev = 1'b0;
    logic        pc_pending = 1'b0;
    int          writes = 0;
    exp_t        last;
    exp_t        item;
    exp_t        sb_q[$];

    assign imem_ack   = resp_ack | force_ack;
    assign imem_rdata = force_ack ? force_data : resp_data;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_din     (ir_din),
        .ir_write_en(ir_write_en),
        .fetch_next (fetch_next),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor and memory responder share one negedge process; the main thread
    // drives its inputs 1 time unit after the negedge, so no race with this block.
    always @(negedge clk) begin
        if (pc_pending) begin
            check("pc_after_load", {24'h0, pc}, {24'h0, last.pc_after});
            check("ir_din_hold", {16'h0, ir_din}, {16'h0, last.data});
            pc_pending = 1'b0;
        end
        if (ack_prev || ir_write_en === 1'b1)
            check("wen_latency", {31'h0, ir_write_en}, {31'h0, ack_prev});
        if (ir_write_en === 1'b1) begin
            writes++;
            check("sb_nonempty", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() != 0) begin
                last = sb_q.pop_front();
                check("ir_din", {16'h0, ir_din}, {16'h0, last.data});
                pc_pending = 1'b1;
            end
        end

        ack_prev = 1'b0;
        resp_ack = 1'b0;
        if (mem_enable && imem_req === 1'b1) begin
            if (in_req) begin
                check("addr_stable", {24'h0, imem_addr}, {24'h0, model_pc});
            end else begin
                check("req_addr", {24'h0, imem_addr}, {24'h0, model_pc});
                wait_cnt = 0;
            end
            in_req = 1'b1;
            if (wait_cnt >= mem_wait) begin
                resp_ack      = 1'b1;
                resp_data     = mem[model_pc];
                item.data     = mem[model_pc];
                item.pc_after = model_pc + 8'd1;
                sb_q.push_back(item);
                ack_prev      = 1'b1;
            end else begin
                resp_data = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            in_req = 1'b0;
        end
    end

    task automatic pulse(input logic fn, input logic je, input logic [7:0] ja);
        @(negedge clk); #1;
        fetch_next = fn;
        jump_en    = je;
        jump_addr  = ja;
        @(negedge clk); #1;
        fetch_next = 1'b0;
        jump_en    = 1'b0;
    endtask

    task automatic wait_exec(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && imem_req === 1'b0 && ir_write_en === 1'b0) ok = 1'b1;
        end
        #1;
        if (!ok) check("exec_timeout", 32'd0, 32'd1);
    endtask

    int w0;

    initial begin
        rst        = 1'b1;
        run        = 1'b1;
        fetch_next = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = 8'h00;
        force_ack  = 1'b1;
        force_data = 16'hBEEF;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A3C;
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;

        // Reset held two cycles with run and ack asserted
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", {24'h0, pc}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'd0);
        check("rst_wen", {31'h0, ir_write_en}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_ir_din", {16'h0, ir_din}, 32'h0);
        force_ack  = 1'b0;
        mem_enable = 1'b1;
        rst        = 1'b0;

        // Sequential zero-wait fetches
        wait_exec(20);
        model_pc = model_pc + 8'd1;
        pulse(1'b1, 1'b0, 8'h00);
        wait_exec(20);
        model_pc = model_pc + 8'd1;
        check("seq_pc", {24'h0, pc}, 32'h2);

        // Wait states; a jump during REQ must be ignored and not queued
        mem_wait = 3;
        pulse(1'b1, 1'b0, 8'h00);
        pulse(1'b1, 1'b1, 8'h80);
        wait_exec(20);
        model_pc = model_pc + 8'd1;
        repeat (3) begin
            @(negedge clk); #1;
            check("exec_hold", {29'h0, busy, imem_req, ir_write_en}, 32'b100);
        end
        mem_wait = 0;

        // Jump and fetch_next together: jump wins, exactly one fetch
        w0       = writes;
        model_pc = 8'h40;
        pulse(1'b1, 1'b1, 8'h40);
        wait_exec(20);
        model_pc = model_pc + 8'd1;
        check("jump_one_write", 32'(writes - w0), 32'd1);

        // PC wrap at 0xFF, then fetch from 0x00
        model_pc = 8'hFF;
        pulse(1'b0, 1'b1, 8'hFF);
        wait_exec(20);
        model_pc = model_pc + 8'd1;
        pulse(1'b1, 1'b0, 8'h00);
        wait_exec(20);
        model_pc = model_pc + 8'd1;

        // Reset in the middle of REQ with ack in the same cycle
        mem_enable = 1'b0;
        w0         = writes;
        pulse(1'b1, 1'b0, 8'h00);
        check("mid_req_req", {31'h0, imem_req}, 32'd1);
        @(negedge clk); #1;
        rst        = 1'b1;
        force_ack  = 1'b1;
        force_data = 16'hDEAD;
        run        = 1'b0;
        @(negedge clk); #1;
        rst       = 1'b0;
        force_ack = 1'b0;
        check("mid_req_req_off", {31'h0, imem_req}, 32'd0);
        check("mid_req_busy", {31'h0, busy}, 32'd0);
        check("mid_req_pc", {24'h0, pc}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("mid_req_no_write", 32'(writes - w0), 32'd0);
        check("mid_req_idle", {31'h0, busy}, 32'd0);

        // Fetch once, then drop run in EXEC and request the next instruction
        model_pc   = 8'h00;
        mem_enable = 1'b1;
        run        = 1'b1;
        wait_exec(20);
        model_pc = model_pc + 8'd1;
        run      = 1'b0;
        pulse(1'b1, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge clk); #1;
            check("park_idle", {30'h0, busy, imem_req}, 32'd0);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
